sigma_delta_adc_decim: RTL and testbench
========================================

Name: sigma_delta_adc_decim

Overview:
- Receive side of the 1-bit audio path: converts a 1-bit sigma-delta bitstream into PCM samples. Source is an external comparator or an on-chip modulator.
- Second-order CIC (sinc2) decimator with decimation ratio R = 2^DECIM_LOG2.
- Output is offset-binary (excess 2^MSBO), the same coding used by the team's PCM-to-1-bit DAC, so a loopback returns the original code.

Parameters:
- MSBO, 7: output MSB index; output width is MSBO+1. Constraint: 2*DECIM_LOG2 >= MSBO+1.
- DECIM_LOG2, 5: log2 of the decimation ratio R (default R = 32).

Ports:
- CLK  input  1  system clock; all state on rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- CE  input  1  bitstream sample enable; one input bit is consumed per CLK with CE=1.
- ADCin  input  1  raw bitstream, possibly asynchronous to CLK.
- ADCout  output  MSBO+1  decimated PCM sample, excess 2^MSBO; registered.
- ADCvalid  output  1  one-CLK strobe, high on the cycle ADCout takes a new value.

Behaviour:
- Reset (RESET_N low, asynchronous): everything below is forced.
  - ADCout = 2^MSBO (mid-scale); ADCvalid = 0.
  - Sync flops, integrators, comb delays, decimation counter, warm-up counter all = 0.
  - Reset takes effect mid-frame with no partial sample emitted. The first post-reset frame starts at counter 0.
- Input sync:
  - ADCin passes through a 2-flop synchroniser every CLK, independent of CE.
  - x = synchronised bit, treated as unsigned 0/1.
- Internal width: W = 2*DECIM_LOG2 + 1 bits. All integrator/comb arithmetic is unsigned modulo 2^W; wrap-around is intentional and must not saturate.
- Integrators, updated only when CE=1:
  - I1 <= I1 + x
  - I2 <= I2 + I1, using the pre-update I1.
- Decimation counter:
  - cnt (DECIM_LOG2 bits) increments on CE and wraps R-1 -> 0.
  - tick = CE && cnt == R-1.
- Comb, evaluated combinationally from the post-update I2 value on the tick cycle:
  - c1 = I2n - Z1; c2 = c1 - Z2.
  - On tick: Z1 <= I2n; Z2 <= c1.
- Scaling and saturation:
  - s = c2 >> (2*DECIM_LOG2 - MSBO - 1).
  - If s > 2^(MSBO+1)-1, output all ones. This occurs only for all-ones input, where c2 = R^2.
- Output register:
  - On tick, ADCout <= saturated s and ADCvalid <= 1 at the same edge.
  - ADCvalid falls the next CLK unless another tick occurs; with CE tied high, the minimum spacing is R CLKs.
- Warm-up:
  - The first 2 ticks after reset only load the comb delays. ADCout is held at mid-scale and ADCvalid stays 0.
  - A 2-bit warm-up counter saturates at 2; ADCvalid is first asserted on the 3rd tick.
- CE low: integrators, counter, comb and ADCout hold; ADCvalid = 0.
- Latency: an input step on ADCin reaches x after 2 CLK. The full sinc2 step response settles in 2R CE-samples, i.e. the 2nd valid tick after the step is fully settled.
- Steady state for constant input density p: ADCout = floor(p*R^2 >> shift), saturated.

Test Plan:
- Reset, then ADCin=0 with CE=1 -> ADCvalid stays 0 for ticks 1-2; from tick 3, ADCvalid pulses every 32 CLK and ADCout = 0x00.
- ADCin=1 constant -> after warm-up, ADCout = 0xFF (c2 = 1024 saturated).
- ADCin alternating 1,0 -> every valid sample ADCout = 0x80.
- Loopback through a bench first-order 1-bit modulator fed codes 0x10, 0x80, 0xC0 -> settled ADCout within ±2 of each code; step settles by the 2nd valid after the change.
- CE pattern 1-of-3 cycles with ADCin=1 -> ADCvalid spacing 96 CLK; ADCout still 0xFF; no state change on CE=0 cycles.
- RESET_N pulsed low mid-frame (cnt=17), then ADCin=1 -> ADCout returns to 0x80 immediately, ADCvalid=0; next valid is the 3rd tick after release, value 0xFF.

Source files
------------

// File: rtl/sigma_delta_adc_decim_if.sv
// Bitstream-in / PCM-out bundle for the sinc2 decimator.
// master drives CE and ADCin; slave returns ADCout and ADCvalid.
interface sigma_delta_adc_decim_if #(
  parameter int MSBO = 7
);
  logic            CE;
  logic            ADCin;
  logic [MSBO:0]   ADCout;
  logic            ADCvalid;

  modport master (
    output CE,
    output ADCin,
    input  ADCout,
    input  ADCvalid
  );

  modport slave (
    input  CE,
    input  ADCin,
    output ADCout,
    output ADCvalid
  );
endinterface

// File: rtl/sigma_delta_adc_decim.sv
// 1-bit sigma-delta bitstream to offset-binary PCM via a sinc2 CIC.
// Decimation R = 2^DECIM_LOG2; arithmetic wraps mod 2^(2*DECIM_LOG2+1).
module sigma_delta_adc_decim #(
  parameter int MSBO       = 7,
  parameter int DECIM_LOG2 = 5
) (
  input  logic CLK,
  input  logic RESET_N,
  sigma_delta_adc_decim_if.slave adc
);

  localparam int W  = 2 * DECIM_LOG2 + 1;
  localparam int OW = MSBO + 1;
  localparam int SH = 2 * DECIM_LOG2 - MSBO - 1;

  localparam logic [MSBO:0] MID = {1'b1, {MSBO{1'b0}}};
  localparam logic [MSBO:0] ONES = {OW{1'b1}};

  logic [1:0]            sync;
  logic                  x;

  logic [W-1:0]          i1;
  logic [W-1:0]          i2;
  logic [W-1:0]          z1;
  logic [W-1:0]          z2;

  logic [W-1:0]          i1_nxt;
  logic [W-1:0]          i2_nxt;
  logic [W-1:0]          c1;
  logic [W-1:0]          c2;
  logic [W-1:0]          scaled;
  logic [MSBO:0]         sat;

  logic [DECIM_LOG2-1:0] cnt;
  logic                  tick;

  logic [1:0]            warm;
  logic                  warm_done;

  logic [MSBO:0]         out_q;
  logic                  valid_q;

  assign x = sync[1];

  // Integrator and comb next-state values; wrap-around is deliberate.
  always_comb begin
    i1_nxt = i1 + {{(W-1){1'b0}}, x};
    i2_nxt = i2 + i1;
    c1     = i2_nxt - z1;
    c2     = c1 - z2;
    scaled = c2 >> SH;
    sat    = scaled[MSBO:0];
    if (|scaled[W-1:OW])
      sat = ONES;
  end

  assign tick      = adc.CE && (&cnt);
  assign warm_done = (warm == 2'd2);

  // Two-flop synchroniser, free-running regardless of CE.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)
      sync <= 2'b00;
    else
      sync <= {sync[0], adc.ADCin};
  end

  // Integrators, decimation counter and comb delays advance on CE.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      i1  <= '0;
      i2  <= '0;
      z1  <= '0;
      z2  <= '0;
      cnt <= '0;
    end else if (adc.CE) begin
      i1  <= i1_nxt;
      i2  <= i2_nxt;
      cnt <= cnt + DECIM_LOG2'(1);
      if (tick) begin
        z1 <= i2_nxt;
        z2 <= c1;
      end
    end
  end

  // First two ticks only prime the comb; output starts on the third.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      warm    <= 2'd0;
      out_q   <= MID;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (tick) begin
        if (warm_done) begin
          out_q   <= sat;
          valid_q <= 1'b1;
        end else begin
          warm <= warm + 2'd1;
        end
      end
    end
  end

  assign adc.ADCout   = out_q;
  assign adc.ADCvalid = valid_q;

endmodule

// File: tb/tb_sigma_delta_adc_decim.sv
// Directed bench for sigma_delta_adc_decim (MSBO=7, R=32).
// Stimulus modes: constant 0/1, alternating, first-order modulator.
module tb_sigma_delta_adc_decim;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  sigma_delta_adc_decim_if #(.MSBO(7)) bus ();

  sigma_delta_adc_decim #(
    .MSBO(7),
    .DECIM_LOG2(5)
  ) dut (
    .CLK(clk),
    .RESET_N(rst_n),
    .adc(bus.slave)
  );

  int checks = 0;
  int errors = 0;

  int mode = 0;
  int ce_mode = 0;
  int phase = 0;
  logic [7:0] code = 8'h00;
  logic [8:0] acc = 9'd0;

  logic v;
  logic [7:0] o;

  task automatic tick1;
    @(negedge clk);
    v = bus.ADCvalid;
    o = bus.ADCout;
    case (mode)
      0: bus.ADCin = 1'b0;
      1: bus.ADCin = 1'b1;
      2: bus.ADCin = ~bus.ADCin;
      default: begin
        acc = acc + {1'b0, code};
        bus.ADCin = acc[8];
        acc[8] = 1'b0;
      end
    endcase
    if (ce_mode == 0) begin
      bus.CE = 1'b1;
    end else begin
      phase = (phase + 1) % 3;
      bus.CE = (phase == 0);
    end
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    do begin
      tick1();
      n++;
    end while (!v && n < max);
  endtask

  task automatic test_reset;
    mode = 0;
    ce_mode = 0;
    bus.CE = 1'b0;
    bus.ADCin = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.ADCout !== 8'h80 || bus.ADCvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: out=%h valid=%b want out=80 valid=0",
               bus.ADCout, bus.ADCvalid);
    end
    rst_n = 1'b1;
    bus.CE = 1'b1;
  endtask

  task automatic test_zero;
    int n;
    wait_valid(200, n);
    checks++;
    if (!v || n != 96) begin
      errors++;
      $display("FAIL zero_first_valid: cycles=%0d valid=%b want 96", n, v);
    end
    checks++;
    if (o !== 8'h00) begin
      errors++;
      $display("FAIL zero_value: out=%h want 00", o);
    end
    wait_valid(100, n);
    checks++;
    if (!v || n != 32) begin
      errors++;
      $display("FAIL zero_spacing: cycles=%0d valid=%b want 32", n, v);
    end
    checks++;
    if (o !== 8'h00) begin
      errors++;
      $display("FAIL zero_value2: out=%h want 00", o);
    end
  endtask

  task automatic test_ones;
    int n;
    mode = 1;
    repeat (2) wait_valid(100, n);
    for (int k = 0; k < 2; k++) begin
      wait_valid(100, n);
      checks++;
      if (!v || n != 32 || o !== 8'hFF) begin
        errors++;
        $display("FAIL ones_%0d: out=%h cycles=%0d want FF/32", k, o, n);
      end
    end
  endtask

  task automatic test_alt;
    int n;
    mode = 2;
    repeat (2) wait_valid(100, n);
    for (int k = 0; k < 2; k++) begin
      wait_valid(100, n);
      checks++;
      if (!v || o !== 8'h80) begin
        errors++;
        $display("FAIL alt_%0d: out=%h valid=%b want 80", k, o, v);
      end
    end
  endtask

  task automatic test_loopback;
    int n;
    int d;
    logic [7:0] codes [3];
    codes[0] = 8'h10;
    codes[1] = 8'h80;
    codes[2] = 8'hC0;
    acc = 9'd0;
    mode = 3;
    for (int k = 0; k < 3; k++) begin
      code = codes[k];
      wait_valid(100, n);
      for (int j = 0; j < 2; j++) begin
        wait_valid(100, n);
        d = int'(o) - int'(code);
        checks++;
        if (!v || d > 2 || d < -2) begin
          errors++;
          $display("FAIL loopback_%h_%0d: out=%h want %h+-2",
                   code, j, o, code);
        end
      end
    end
  endtask

  task automatic test_ce_pattern;
    int n;
    bit bad;
    mode = 1;
    ce_mode = 1;
    repeat (3) wait_valid(400, n);
    wait_valid(400, n);
    checks++;
    if (!v || n != 96 || o !== 8'hFF) begin
      errors++;
      $display("FAIL ce_spacing: cycles=%0d out=%h want 96/FF", n, o);
    end
    bad = 1'b0;
    for (int k = 0; k < 95; k++) begin
      tick1();
      if (v || o !== 8'hFF)
        bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL ce_hold: output moved between ticks, want FF/0");
    end
    ce_mode = 0;
  endtask

  task automatic test_reset_mid;
    int n;
    mode = 1;
    ce_mode = 0;
    wait_valid(400, n);
    repeat (17) tick1();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.ADCout !== 8'h80 || bus.ADCvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: out=%h valid=%b want 80/0",
               bus.ADCout, bus.ADCvalid);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_valid(200, n);
    checks++;
    if (!v || n != 96) begin
      errors++;
      $display("FAIL reset_mid_first: cycles=%0d want 96", n);
    end
    checks++;
    if (o !== 8'hFF) begin
      errors++;
      $display("FAIL reset_mid_value: out=%h want FF", o);
    end
  endtask

  initial begin
    bus.CE = 1'b0;
    bus.ADCin = 1'b0;
    test_reset();
    test_zero();
    test_ones();
    test_alt();
    test_loopback();
    test_ce_pattern();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
